// File: rtl/ex_stage_md.sv
// ex_stage_md: MIPS execute stage with forwarding, RegDst select, ALU and an iterative mul/div unit.
// The datapath is combinational. mult/div take XLEN cycles, and HI/LO are readable the cycle after.
// MDStallE holds IF/ID/EX while an MD op or mfhi/mflo is waiting on the busy unit.
module ex_stage_md #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int MD_CNTW = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        ALUControlE,
  input  logic              ALUSrcE,
  input  logic              RegDstE,
  input  logic [2:0]        MDOpE,
  input  logic              ValidE,
  input  logic [XLEN-1:0]   SrcADinE,
  input  logic [XLEN-1:0]   SrcBDinE,
  input  logic [XLEN-1:0]   SignImmE,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [XLEN-1:0]   ALUOutM,
  input  logic [XLEN-1:0]   ResultW,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  output logic [XLEN-1:0]   ALUOutE,
  output logic [XLEN-1:0]   WriteDataE,
  output logic [REG_AW-1:0] WriteRegE,
  output logic              MDStallE,
  output logic              MDBusy
);

  localparam logic [2:0] OP_MULT = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_DIVU = 3'd4;
  localparam logic [2:0] OP_MFHI = 3'd5;
  localparam logic [2:0] OP_MFLO = 3'd6;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} md_state_e;

  md_state_e          state_q, state_d;
  logic [XLEN-1:0]    src_a, src_b, alu_res;
  logic [XLEN-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]    acc_q, acc_d, wq_q, wq_d, opnd_q, opnd_d;
  logic [MD_CNTW-1:0] cnt_q, cnt_d;
  logic               is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d;
  logic               md_start, last_step, signed_op, a_neg, b_neg;
  logic [XLEN-1:0]    mag_a, mag_b, acc_step, wq_step, q_fin, r_fin;
  logic [XLEN:0]      mul_sum, div_shift;
  logic               div_take;
  logic [2*XLEN-1:0]  prod, prod_fin;

  // Operand forwarding: 01 takes the WB result, 10 the MEM result, otherwise the register file
  always_comb begin
    src_a = SrcADinE;
    if (ForwardAE == 2'b01) src_a = ResultW;
    else if (ForwardAE == 2'b10) src_a = ALUOutM;
    WriteDataE = SrcBDinE;
    if (ForwardBE == 2'b01) WriteDataE = ResultW;
    else if (ForwardBE == 2'b10) WriteDataE = ALUOutM;
  end

  assign src_b     = ALUSrcE ? SignImmE : WriteDataE;
  assign WriteRegE = RegDstE ? RdE : RtE;

  // Single-cycle ALU; mfhi/mflo replace its result with the registered HI/LO
  always_comb begin
    alu_res = '0;
    unique case (ALUControlE)
      3'b000: alu_res = src_a & src_b;
      3'b001: alu_res = src_a | src_b;
      3'b010: alu_res = src_a + src_b;
      3'b100: alu_res = src_a & ~src_b;
      3'b101: alu_res = src_a | ~src_b;
      3'b110: alu_res = src_a - src_b;
      3'b111: alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_res = '0;
    endcase
    ALUOutE = alu_res;
    if (MDOpE == OP_MFHI) ALUOutE = hi_q;
    else if (MDOpE == OP_MFLO) ALUOutE = lo_q;
  end

  // Stall any MD consumer while the unit runs; a new op starts only from IDLE without a stall
  assign MDStallE  = ValidE & MDBusy & (MDOpE inside {[3'd1:3'd6]});
  assign md_start  = (state_q == S_IDLE) & ValidE & (MDOpE inside {[3'd1:3'd4]}) & ~MDStallE;
  assign last_step = (state_q == S_RUN) && (cnt_q == MD_CNTW'(XLEN - 1));

  // Signed ops run on magnitudes and fix the result signs on the final edge
  assign signed_op = (MDOpE == OP_MULT) || (MDOpE == OP_DIV);
  assign a_neg     = signed_op & src_a[XLEN-1];
  assign b_neg     = signed_op & WriteDataE[XLEN-1];
  assign mag_a     = a_neg ? ('0 - src_a) : src_a;
  assign mag_b     = b_neg ? ('0 - WriteDataE) : WriteDataE;

  // One iteration: shift-add for multiply, restoring subtract for divide
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (wq_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q, wq_q[XLEN-1]};
    div_take  = div_shift >= {1'b0, opnd_q};
    if (is_div_q) begin
      acc_step = div_take ? (div_shift[XLEN-1:0] - opnd_q) : div_shift[XLEN-1:0];
      wq_step  = {wq_q[XLEN-2:0], div_take};
    end else begin
      acc_step = mul_sum[XLEN:1];
      wq_step  = {mul_sum[0], wq_q[XLEN-1:1]};
    end
    prod     = {acc_step, wq_step};
    prod_fin = neg_q ? ('0 - prod) : prod;
    q_fin    = neg_q ? ('0 - wq_step) : wq_step;
    r_fin    = rneg_q ? ('0 - acc_step) : acc_step;
  end

  // Next state of the MD datapath. A zero divisor makes every restoring step succeed, which
  // yields an all-ones quotient and leaves the dividend as the remainder. The quotient sign
  // flag is therefore suppressed for that case so that LO stays all ones.
  always_comb begin
    acc_d    = acc_q;
    wq_d     = wq_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (md_start) begin
      acc_d    = '0;
      wq_d     = mag_a;
      opnd_d   = mag_b;
      cnt_d    = '0;
      is_div_d = (MDOpE == OP_DIV) || (MDOpE == OP_DIVU);
      neg_d    = (a_neg ^ b_neg) & ~(is_div_d & (WriteDataE == '0));
      rneg_d   = a_neg;
    end else if (state_q == S_RUN) begin
      acc_d = acc_step;
      wq_d  = wq_step;
      cnt_d = cnt_q + MD_CNTW'(1);
      if (last_step) begin
        if (is_div_q) begin
          hi_d = r_fin;
          lo_d = q_fin;
        end else begin
          {hi_d, lo_d} = prod_fin;
        end
      end
    end
  end

  // MD datapath registers; reset discards any running operation and clears HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      wq_q     <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      acc_q    <= acc_d;
      wq_q     <= wq_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: IDLE -> RUN on start, RUN -> IDLE on the final step
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (md_start) state_d = S_RUN;
      S_RUN:  if (last_step) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    MDBusy = (state_q == S_RUN);
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// Testbench for ex_stage_md: random ALU/forwarding checks and mul/div against arithmetic models.
// A 32-bit instance covers most scenarios; a 16-bit instance reruns multiply and random MD ops.
// Inputs are driven away from rising edges, and outputs are sampled on falling edges or 1ns later.
module tb_ex_stage_md;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  ALUControlE = '0;
  logic        ALUSrcE = 1'b0, RegDstE = 1'b0, ValidE = 1'b0, ValidE16 = 1'b0;
  logic [2:0]  MDOpE = '0;
  logic [31:0] SrcADinE = '0, SrcBDinE = '0, SignImmE = '0, ALUOutM = '0, ResultW = '0;
  logic [4:0]  RdE = '0, RtE = '0;
  logic [1:0]  ForwardAE = '0, ForwardBE = '0;
  logic [31:0] ALUOutE, WriteDataE;
  logic [4:0]  WriteRegE, WriteReg16;
  logic        MDStallE, MDBusy, MDStall16, MDBusy16;
  logic [15:0] a16 = '0, b16 = '0;
  logic [15:0] ALUOut16, WriteData16;

  int checks = 0;
  int failures = 0;
  logic [31:0] hi_m = '0, lo_m = '0;

  always #5 clk = ~clk;

  ex_stage_md #(.XLEN(32), .REG_AW(5), .MD_CNTW(6)) dut (
    .clk(clk), .rst_n(rst_n), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE),
    .MDOpE(MDOpE), .ValidE(ValidE), .SrcADinE(SrcADinE), .SrcBDinE(SrcBDinE), .SignImmE(SignImmE),
    .RdE(RdE), .RtE(RtE), .ALUOutM(ALUOutM), .ResultW(ResultW), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
    .MDStallE(MDStallE), .MDBusy(MDBusy)
  );

  ex_stage_md #(.XLEN(16), .REG_AW(5), .MD_CNTW(5)) dut16 (
    .clk(clk), .rst_n(rst_n), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE),
    .MDOpE(MDOpE), .ValidE(ValidE16), .SrcADinE(a16), .SrcBDinE(b16), .SignImmE(16'h0),
    .RdE(RdE), .RtE(RtE), .ALUOutM(16'h0), .ResultW(16'h0), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .ALUOutE(ALUOut16), .WriteDataE(WriteData16), .WriteRegE(WriteReg16),
    .MDStallE(MDStall16), .MDBusy(MDBusy16)
  );

  // ---------------- reference models ----------------
  function automatic logic [31:0] fwd_ref(input logic [1:0] sel, input logic [31:0] r,
                                          input logic [31:0] m, input logic [31:0] w);
    if (sel == 2'b01) return w;
    if (sel == 2'b10) return m;
    return r;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] ctl, input logic [31:0] a,
                                          input logic [31:0] b);
    case (ctl)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd4: return a & ~b;
      3'd5: return a | ~b;
      3'd6: return a - b;
      3'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Returns {HI, LO}
  function automatic logic [63:0] md_ref32(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (op)
      3'd1: res = sa * sb;
      3'd2: res = {32'h0, a} * {32'h0, b};
      3'd3: if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
            else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
      3'd4: if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
            else res = {a % b, a / b};
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] md_ref16(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
    int sa, sb, q, r;
    logic [31:0] res;
    sa = int'($signed(a));
    sb = int'($signed(b));
    res = '0;
    case (op)
      3'd1: res = sa * sb;
      3'd2: res = {16'h0, a} * {16'h0, b};
      3'd3: if (b == 16'h0) res = {a, 16'hFFFF};
            else begin q = sa / sb; r = sa % sb; res = {r[15:0], q[15:0]}; end
      3'd4: if (b == 16'h0) res = {a, 16'hFFFF};
            else res = {a % b, a / b};
      default: res = '0;
    endcase
    return res;
  endfunction

  // ---------------- drive helpers (no checking) ----------------
  task automatic start_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    ForwardAE = 2'b00; ForwardBE = 2'b00;
    SrcADinE = a; SrcBDinE = b; MDOpE = op; ValidE = 1'b1;
    @(posedge clk); #1;
    ValidE = 1'b0; MDOpE = 3'd0;
  endtask

  // Counts cycles with MDBusy high, bounded at 200
  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (MDBusy === 1'b1 && n < 200) begin n++; @(negedge clk); end
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    MDOpE = 3'd5; #1 h = ALUOutE;
    MDOpE = 3'd6; #1 l = ALUOutE;
    MDOpE = 3'd0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [31:0] h, l;
    ValidE = 1'b1; MDOpE = 3'd5;
    #2;
    checks++; if (MDBusy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", MDBusy); end
    checks++; if (MDStallE !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", MDStallE); end
    ValidE = 1'b0;
    read_hilo(h, l);
    checks++; if (h !== 32'h0 || l !== 32'h0) begin failures++; $display("FAIL reset_hilo got=%h_%h exp=0_0", h, l); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hi_m = '0; lo_m = '0;
  endtask

  task automatic test_forward_example;
    @(negedge clk);
    ForwardAE = 2'b10; ALUOutM = 32'h10; SrcADinE = 32'h1; ALUControlE = 3'b010;
    SignImmE = 32'h4; ALUSrcE = 1'b1; ValidE = 1'b1; MDOpE = 3'd0;
    #1;
    checks++; if (ALUOutE !== 32'h14) begin failures++; $display("FAIL fwd_example got=%h exp=00000014", ALUOutE); end
    ValidE = 1'b0;
  endtask

  task automatic test_alu_random;
    logic [31:0] ea, eb, ebsrc;
    logic [4:0]  ewr;
    logic [2:0]  ctl;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      do ctl = 3'($urandom_range(0, 7)); while (ctl == 3'd3);
      ALUControlE = ctl; ALUSrcE = 1'($urandom); RegDstE = 1'($urandom);
      ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
      SrcADinE = $urandom; SrcBDinE = $urandom; SignImmE = $urandom;
      ALUOutM = $urandom; ResultW = $urandom; RdE = 5'($urandom); RtE = 5'($urandom);
      ValidE = 1'($urandom); MDOpE = ($urandom_range(0, 1) != 0) ? 3'd7 : 3'd0;
      ea = fwd_ref(ForwardAE, SrcADinE, ALUOutM, ResultW);
      eb = fwd_ref(ForwardBE, SrcBDinE, ALUOutM, ResultW);
      ebsrc = ALUSrcE ? SignImmE : eb;
      ewr = RegDstE ? RdE : RtE;
      #1;
      checks++; if (ALUOutE !== alu_ref(ctl, ea, ebsrc)) begin failures++;
        $display("FAIL alu_rand ctl=%0d got=%h exp=%h", ctl, ALUOutE, alu_ref(ctl, ea, ebsrc)); end
      checks++; if (WriteDataE !== eb || WriteRegE !== ewr) begin failures++;
        $display("FAIL wdata_wreg got=%h/%0d exp=%h/%0d", WriteDataE, WriteRegE, eb, ewr); end
    end
    ValidE = 1'b0; MDOpE = 3'd0;
  endtask

  task automatic test_mult_example;
    int n;
    logic [31:0] h, l;
    @(negedge clk);
    start_md(3'd1, 32'hFFFF_FFFD, 32'd5);
    wait_idle(n);
    checks++; if (n !== 32) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=32", n); end
    read_hilo(h, l);
    hi_m = 32'hFFFF_FFFF; lo_m = 32'hFFFF_FFF1;
    checks++; if (h !== hi_m || l !== lo_m) begin failures++;
      $display("FAIL mult_example got=%h_%h exp=%h_%h", h, l, hi_m, lo_m); end
  endtask

  task automatic test_divu_stall;
    int n;
    @(negedge clk);
    ForwardAE = 2'b00; ForwardBE = 2'b00;
    SrcADinE = 32'd100; SrcBDinE = 32'd7; MDOpE = 3'd4; ValidE = 1'b1;
    @(posedge clk); #1;
    MDOpE = 3'd5;
    n = 0;
    @(negedge clk);
    while (MDStallE === 1'b1 && n < 200) begin n++; @(negedge clk); end
    checks++; if (n !== 32) begin failures++; $display("FAIL divu_stall_cycles got=%0d exp=32", n); end
    checks++; if (ALUOutE !== 32'd2) begin failures++; $display("FAIL divu_mfhi got=%h exp=00000002", ALUOutE); end
    checks++; if (MDBusy !== 1'b0) begin failures++; $display("FAIL divu_busy_after got=%b exp=0", MDBusy); end
    @(posedge clk); #1;
    MDOpE = 3'd6;
    #1;
    checks++; if (ALUOutE !== 32'd14) begin failures++; $display("FAIL divu_mflo got=%h exp=0000000e", ALUOutE); end
    ValidE = 1'b0; MDOpE = 3'd0;
    hi_m = 32'd2; lo_m = 32'd14;
  endtask

  task automatic test_div_corners;
    logic [2:0]  ops [5] = '{3'd3, 3'd3, 3'd3, 3'd4, 3'd3};
    logic [31:0] av  [5] = '{32'd7, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'hFFFF_FFF7};
    logic [31:0] bv  [5] = '{32'd0, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] eh  [5] = '{32'd7, 32'hFFFF_FFFF, 32'h0, 32'd5, 32'hFFFF_FFF7};
    logic [31:0] el  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    int n;
    logic [31:0] h, l;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_md(ops[i], av[i], bv[i]);
      wait_idle(n);
      read_hilo(h, l);
      checks++; if (h !== eh[i] || l !== el[i] || n !== 32) begin failures++;
        $display("FAIL div_corner%0d got=%h_%h/%0d exp=%h_%h/32", i, h, l, n, eh[i], el[i]); end
      hi_m = eh[i]; lo_m = el[i];
    end
  endtask

  task automatic test_flush_no_start;
    logic [31:0] h, l;
    int busy_seen;
    @(negedge clk);
    SrcADinE = 32'hFFFF_FFFF; SrcBDinE = 32'hFFFF_FFFF; MDOpE = 3'd2; ValidE = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (MDBusy !== 1'b0) busy_seen++;
    end
    checks++; if (busy_seen !== 0) begin failures++; $display("FAIL flush_busy got=%0d exp=0", busy_seen); end
    read_hilo(h, l);
    checks++; if (h !== hi_m || l !== lo_m) begin failures++;
      $display("FAIL flush_hilo got=%h_%h exp=%h_%h", h, l, hi_m, lo_m); end
  endtask

  task automatic test_random_md;
    logic [2:0]  op;
    logic [31:0] a, b, h, l;
    logic [63:0] e;
    int n;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      op = 3'($urandom_range(1, 4));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 15));
        1: b = 32'h0 - 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      start_md(op, a, b);
      wait_idle(n);
      read_hilo(h, l);
      e = md_ref32(op, a, b);
      checks++; if (h !== e[63:32] || l !== e[31:0] || n !== 32) begin failures++;
        $display("FAIL md_rand op=%0d a=%h b=%h got=%h_%h/%0d exp=%h_%h/32", op, a, b, h, l, n, e[63:32], e[31:0]); end
      hi_m = e[63:32]; lo_m = e[31:0];
    end
  endtask

  task automatic test_alu_during_run;
    logic [31:0] a, b, h, l, ea, ex;
    logic [63:0] e;
    int n;
    @(negedge clk);
    a = $urandom; b = $urandom;
    start_md(3'd1, a, b);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ValidE = 1'b1; MDOpE = 3'd0; ALUControlE = 3'd2; ALUSrcE = 1'b0;
      ForwardAE = 2'b01; ForwardBE = 2'b00; ResultW = $urandom; SrcBDinE = $urandom;
      ea = ResultW; ex = ea + SrcBDinE;
      #1;
      checks++; if (MDStallE !== 1'b0 || MDBusy !== 1'b1 || ALUOutE !== ex) begin failures++;
        $display("FAIL alu_during_run stall=%b busy=%b got=%h exp=0/1/%h", MDStallE, MDBusy, ALUOutE, ex); end
    end
    ValidE = 1'b0; ForwardAE = 2'b00;
    wait_idle(n);
    read_hilo(h, l);
    e = md_ref32(3'd1, a, b);
    checks++; if (h !== e[63:32] || l !== e[31:0] || n + 5 !== 32) begin failures++;
      $display("FAIL run_after_alu got=%h_%h/%0d exp=%h_%h/32", h, l, n + 5, e[63:32], e[31:0]); end
    hi_m = e[63:32]; lo_m = e[31:0];
  endtask

  task automatic test_reset_midrun;
    logic [31:0] h;
    @(negedge clk);
    start_md(3'd1, 32'hFFFF_FFFD, 32'd5);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    ValidE = 1'b1; MDOpE = 3'd5;
    #1;
    hi_m = '0; lo_m = '0;
    checks++; if (MDBusy !== 1'b0 || MDStallE !== 1'b0) begin failures++;
      $display("FAIL midrun_reset busy=%b stall=%b exp=0/0", MDBusy, MDStallE); end
    h = ALUOutE;
    MDOpE = 3'd6; #1;
    checks++; if (h !== 32'h0 || ALUOutE !== 32'h0) begin failures++;
      $display("FAIL midrun_reset_hilo got=%h_%h exp=0_0", h, ALUOutE); end
    ValidE = 1'b0; MDOpE = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_xlen16;
    logic [2:0]  op;
    logic [15:0] h, l;
    logic [31:0] e;
    int n;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin op = 3'd1; a16 = 16'hFFFD; b16 = 16'd5; end
      else begin
        op = 3'($urandom_range(1, 4)); a16 = 16'($urandom);
        b16 = (i == 3) ? 16'h0 : 16'($urandom);
      end
      ValidE = 1'b0; ValidE16 = 1'b1; MDOpE = op;
      @(posedge clk); #1;
      ValidE16 = 1'b0; MDOpE = 3'd0;
      n = 0;
      @(negedge clk);
      while (MDBusy16 === 1'b1 && n < 200) begin n++; @(negedge clk); end
      MDOpE = 3'd5; #1 h = ALUOut16;
      MDOpE = 3'd6; #1 l = ALUOut16;
      MDOpE = 3'd0;
      e = md_ref16(op, a16, b16);
      checks++; if (h !== e[31:16] || l !== e[15:0] || n !== 16) begin failures++;
        $display("FAIL x16 op=%0d a=%h b=%h got=%h_%h/%0d exp=%h_%h/16", op, a16, b16, h, l, n, e[31:16], e[15:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_forward_example();
    test_alu_random();
    test_mult_example();
    test_divu_stall();
    test_div_corners();
    test_flush_no_start();
    test_random_md();
    test_alu_during_run();
    test_reset_midrun();
    test_xlen16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
